// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage carrying an opaque payload, with flush, an optional
// 2-entry skid buffer (registered in_ready) and a saturating bubble counter.
module pipe_stage_skid #(
    parameter int DATA_W = 64,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic acc;
    logic drn;
    logic [CNT_W-1:0] cnt_reg;

    assign acc = in_valid & in_ready;
    assign drn = out_valid & out_ready;

    generate
        if (SKID != 0) begin : g_skid
            localparam logic [1:0] ST_EMPTY = 2'd0;
            localparam logic [1:0] ST_BUSY  = 2'd1;
            localparam logic [1:0] ST_FULL  = 2'd2;

            logic [1:0]        state_reg, state_next;
            logic [DATA_W-1:0] main_reg, main_next;
            logic [DATA_W-1:0] skid_reg, skid_next;
            logic              in_ready_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_reg    <= ST_EMPTY;
                    main_reg     <= '0;
                    skid_reg     <= '0;
                    in_ready_reg <= 1'b1;
                end else begin
                    state_reg    <= state_next;
                    main_reg     <= main_next;
                    skid_reg     <= skid_next;
                    // Precomputed from the next state so in_ready never depends on out_ready.
                    in_ready_reg <= (state_next != ST_FULL);
                end
            end

            always_comb begin
                state_next = state_reg;
                main_next  = main_reg;
                skid_next  = skid_reg;
                if (flush) begin
                    state_next = ST_EMPTY;
                    main_next  = '0;
                    skid_next  = '0;
                end else begin
                    case (state_reg)
                        ST_EMPTY: begin
                            if (acc) begin
                                state_next = ST_BUSY;
                                main_next  = in_data;
                            end
                        end
                        ST_BUSY: begin
                            if (acc && drn) begin
                                main_next = in_data;
                            end else if (acc) begin
                                state_next = ST_FULL;
                                skid_next  = in_data;
                            end else if (drn) begin
                                state_next = ST_EMPTY;
                                main_next  = '0;
                            end
                        end
                        ST_FULL: begin
                            if (drn) begin
                                state_next = ST_BUSY;
                                main_next  = skid_reg;
                                skid_next  = '0;
                            end
                        end
                        default: begin
                            state_next = ST_EMPTY;
                            main_next  = '0;
                            skid_next  = '0;
                        end
                    endcase
                end
            end

            always_comb begin
                out_valid = (state_reg != ST_EMPTY);
                in_ready  = in_ready_reg;
                out_data  = out_valid ? main_reg : '0;
            end
        end else begin : g_single
            logic              valid_reg;
            logic [DATA_W-1:0] main_reg;

            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    valid_reg <= 1'b0;
                    main_reg  <= '0;
                end else if (acc) begin
                    valid_reg <= 1'b1;
                    main_reg  <= in_data;
                end else if (drn) begin
                    valid_reg <= 1'b0;
                    main_reg  <= '0;
                end
            end

            assign out_valid = valid_reg;
            assign in_ready  = ~valid_reg | out_ready;
            assign out_data  = valid_reg ? main_reg : '0;
        end
    endgenerate

    // Counts idle output cycles; flush deliberately leaves it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (!out_valid && (cnt_reg != {CNT_W{1'b1}})) begin
            cnt_reg <= cnt_reg + CNT_ONE;
        end
    end

    assign bubble_cnt = cnt_reg;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: a skid instance (CNT_W=3) and a single-register instance
// share one stimulus stream; a queue model predicts both, plus literal spot checks.
module tb_pipe_stage_skid;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       in_valid = 1'b1;
    logic [7:0] in_data = 8'hAA;
    logic       out_ready = 1'b0;

    logic       a_in_ready, a_out_valid;
    logic [7:0] a_out_data;
    logic [2:0] a_bubble;
    logic       b_in_ready, b_out_valid;
    logic [7:0] b_out_data;
    logic [15:0] b_bubble;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(8), .SKID(1), .CNT_W(3)) dut_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
        .bubble_cnt(a_bubble)
    );

    pipe_stage_skid #(.DATA_W(8), .SKID(0), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
        .bubble_cnt(b_bubble)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // Behavioural model: each stage is a FIFO of bounded capacity.
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    int  cnt_a = 0;
    int  cnt_b = 0;
    bit  live = 0;

    function automatic bit exp_a_ready();
        return qa.size() < 2;
    endfunction

    function automatic bit exp_b_ready();
        return (qb.size() == 0) || out_ready;
    endfunction

    always @(posedge clk) begin
        bit acc_a, drn_a, acc_b, drn_b;
        acc_a = in_valid && exp_a_ready();
        drn_a = (qa.size() > 0) && out_ready;
        acc_b = in_valid && exp_b_ready();
        drn_b = (qb.size() > 0) && out_ready;
        if (rst) begin
            qa.delete();
            qb.delete();
            cnt_a = 0;
            cnt_b = 0;
            live  = 1;
        end else begin
            if (qa.size() == 0 && cnt_a < 7) cnt_a++;
            if (qb.size() == 0 && cnt_b < 65535) cnt_b++;
            if (drn_a) $display("xfer dut_a data=%h", qa.pop_front());
            if (drn_b) $display("xfer dut_b data=%h", qb.pop_front());
            if (flush) begin
                qa.delete();
                qb.delete();
            end else begin
                if (acc_a) qa.push_back(in_data);
                if (acc_b) qb.push_back(in_data);
            end
        end
    end

    always @(negedge clk) begin
        #1;
        if (live) begin
            chk("a_in_ready",  32'(a_in_ready),  32'(exp_a_ready()));
            chk("a_out_valid", 32'(a_out_valid), 32'(qa.size() > 0));
            chk("a_out_data",  32'(a_out_data),  (qa.size() > 0) ? 32'(qa[0]) : 32'd0);
            chk("a_bubble",    32'(a_bubble),    32'(cnt_a));
            chk("b_in_ready",  32'(b_in_ready),  32'(exp_b_ready()));
            chk("b_out_valid", 32'(b_out_valid), 32'(qb.size() > 0));
            chk("b_out_data",  32'(b_out_data),  (qb.size() > 0) ? 32'(qb[0]) : 32'd0);
            chk("b_bubble",    32'(b_bubble),    32'(cnt_b));
        end
    end

    task automatic step(input logic r, input logic f, input logic v, input logic [7:0] d,
                        input logic o);
        @(negedge clk);
        rst = r; flush = f; in_valid = v; in_data = d; out_ready = o;
        #1;
    endtask

    initial begin
        // Reset held with a beat offered
        step(1, 0, 1, 8'hAA, 0);
        step(1, 0, 1, 8'hAA, 0);
        chk("rst_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_out_data",  32'(a_out_data),  32'd0);
        chk("rst_bubble",    32'(a_bubble),    32'd0);
        step(0, 0, 0, 8'h00, 1);
        chk("rst_in_ready",  32'(a_in_ready),  32'd1);

        // Streaming
        step(0, 0, 1, 8'h01, 1);
        chk("s_in_ready", 32'(a_in_ready), 32'd1);
        step(0, 0, 1, 8'h02, 1);
        chk("s_data1", 32'(a_out_data), 32'h01);
        step(0, 0, 1, 8'h03, 1);
        chk("s_data2", 32'(a_out_data), 32'h02);
        step(0, 0, 0, 8'h00, 1);
        chk("s_data3", 32'(a_out_data), 32'h03);
        chk("s_ready3", 32'(a_in_ready), 32'd1);
        step(0, 0, 0, 8'h00, 0);
        chk("s_empty", 32'(a_out_valid), 32'd0);

        // Backpressure
        step(0, 0, 1, 8'h10, 0);
        step(0, 0, 1, 8'h11, 0);
        chk("bp_data", 32'(a_out_data), 32'h10);
        chk("bp_b_ready", 32'(b_in_ready), 32'd0);
        step(0, 0, 0, 8'h00, 0);
        chk("bp_full_ready", 32'(a_in_ready), 32'd0);
        chk("bp_hold", 32'(a_out_data), 32'h10);
        step(0, 0, 0, 8'h00, 1);
        chk("bp_hold2", 32'(a_out_data), 32'h10);
        step(0, 0, 0, 8'h00, 1);
        chk("bp_second", 32'(a_out_data), 32'h11);
        chk("bp_ready_back", 32'(a_in_ready), 32'd1);
        step(0, 0, 0, 8'h00, 0);

        // Flush while full, then flush dropping an accepted beat
        step(0, 0, 1, 8'h20, 0);
        step(0, 0, 1, 8'h21, 0);
        step(0, 1, 1, 8'h55, 0);
        chk("fl_full_ready", 32'(a_in_ready), 32'd0);
        step(0, 0, 0, 8'h00, 1);
        chk("fl_valid", 32'(a_out_valid), 32'd0);
        chk("fl_data", 32'(a_out_data), 32'd0);
        chk("fl_bubble", 32'(a_bubble), 32'd6);
        step(0, 1, 1, 8'h66, 1);
        step(0, 0, 0, 8'h00, 1);
        chk("fl_drop", 32'(a_out_valid), 32'd0);

        // Single-register drain and refill in one cycle
        step(0, 0, 1, 8'h30, 0);
        step(0, 0, 1, 8'h31, 0);
        chk("ns_ready_low", 32'(b_in_ready), 32'd0);
        step(0, 0, 1, 8'h31, 1);
        chk("ns_ready_high", 32'(b_in_ready), 32'd1);
        chk("ns_data0", 32'(b_out_data), 32'h30);
        step(0, 0, 0, 8'h00, 0);
        chk("ns_refill", 32'(b_out_data), 32'h31);
        chk("ns_valid", 32'(b_out_valid), 32'd1);
        step(0, 0, 0, 8'h00, 1);
        step(0, 0, 0, 8'h00, 1);

        // Mixed directed pattern
        for (int i = 0; i < 32; i++)
            step(0, i == 17, (i % 3) != 0, 8'(8'h40 + i), (i % 4) != 1);

        // Bubble counter saturation, flush immunity, reset clear
        for (int i = 0; i < 10; i++) step(0, 0, 0, 8'h00, 1);
        chk("sat", 32'(a_bubble), 32'd7);
        step(0, 1, 0, 8'h00, 1);
        step(0, 0, 0, 8'h00, 1);
        chk("sat_flush", 32'(a_bubble), 32'd7);
        step(1, 0, 0, 8'h00, 1);
        step(0, 0, 0, 8'h00, 1);
        chk("sat_rst", 32'(a_bubble), 32'd0);
        chk("sat_rst_b", 32'(b_bubble), 32'd0);
        step(0, 0, 0, 8'h00, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
